// File: rtl/i2c_target.sv
// ============================================================================
// i2c_target : I2C target answering one 7-bit address with 16-bit read/write
// Optional: GENERAL_CALL_EN adds general-call write acceptance and GC_HIT.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'b0000010,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        SCL,
    input  logic        SDA_IN,
    output logic        SDA_OUT,
    output logic        SDA_OE,
    input  logic [15:0] RD_DATA,
    output logic [15:0] WR_DATA,
    output logic        WR_STB,
    output logic        RD_STB,
    output logic        BUSY
`ifdef GENERAL_CALL_EN
    ,
    output logic        GC_HIT
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_BYTE   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_BYTE   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    // Synchronizers reset to 1 so an idle bus is seen straight out of reset.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_IN};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  =  scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s &  scl_prev;
    // SDA edges are qualified by the previous SCL sample, so a coincident SCL edge cannot mask them.
    assign start_det =  sda_prev & ~sda_s & scl_prev;
    assign stop_det  = ~sda_prev &  sda_s & scl_prev;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_in;
    logic [7:0]  hi_byte;
    logic [15:0] rd_shift;
    logic        second;
    logic        rnw;
    logic        master_nack;

    logic addr_match;
    logic gc_match;

    assign addr_match = (shift_in[7:1] == TARGET_ADDR);
`ifdef GENERAL_CALL_EN
    assign gc_match   = (shift_in[7:1] == 7'd0) && !shift_in[0];
`else
    assign gc_match   = 1'b0;
`endif

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state       <= ST_IDLE;
            SDA_OUT     <= 1'b0;
            SDA_OE      <= 1'b0;
            WR_DATA     <= 16'd0;
            WR_STB      <= 1'b0;
            RD_STB      <= 1'b0;
            BUSY        <= 1'b0;
            bit_cnt     <= 4'd0;
            shift_in    <= 8'd0;
            hi_byte     <= 8'd0;
            rd_shift    <= 16'd0;
            second      <= 1'b0;
            rnw         <= 1'b0;
            master_nack <= 1'b0;
`ifdef GENERAL_CALL_EN
            GC_HIT      <= 1'b0;
`endif
        end else begin
            WR_STB <= 1'b0;
            RD_STB <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                SDA_OE  <= 1'b0;
                SDA_OUT <= 1'b0;
                BUSY    <= 1'b0;
`ifdef GENERAL_CALL_EN
                GC_HIT  <= 1'b0;
`endif
            end else if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                second  <= 1'b0;
                SDA_OE  <= 1'b0;
                SDA_OUT <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end

                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_in <= {shift_in[6:0], sda_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (addr_match || gc_match) begin
                                state   <= ST_ADDR_ACK;
                                SDA_OE  <= 1'b1;
                                SDA_OUT <= 1'b0;
                                BUSY    <= 1'b1;
                                rnw     <= shift_in[0];
                                if (shift_in[0]) begin
                                    rd_shift <= RD_DATA;
                                    RD_STB   <= 1'b1;
                                end
`ifdef GENERAL_CALL_EN
                                GC_HIT  <= GC_HIT | gc_match;
`endif
                            end else begin
                                state <= ST_WAIT_STOP;
                                BUSY  <= 1'b0;
                            end
                        end
                    end

                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rnw) begin
                                state   <= ST_RD_BYTE;
                                SDA_OE  <= 1'b1;
                                SDA_OUT <= rd_shift[15];
                            end else begin
                                state   <= ST_WR_BYTE;
                                SDA_OE  <= 1'b0;
                                SDA_OUT <= 1'b0;
                            end
                        end
                    end

                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            shift_in <= {shift_in[6:0], sda_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state   <= ST_WR_ACK;
                            bit_cnt <= 4'd0;
                            SDA_OE  <= 1'b1;
                            SDA_OUT <= 1'b0;
                            if (!second) begin
                                hi_byte <= shift_in;
                            end else begin
                                WR_DATA <= {hi_byte, shift_in};
                                WR_STB  <= 1'b1;
                            end
                        end
                    end

                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            SDA_OE  <= 1'b0;
                            bit_cnt <= 4'd0;
                            if (!second) begin
                                state  <= ST_WR_BYTE;
                                second <= 1'b1;
                            end else begin
                                state  <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            // The eighth shift leaves the next byte's MSB in rd_shift[15].
                            rd_shift <= {rd_shift[14:0], 1'b0};
                            if (bit_cnt == 4'd8) begin
                                state   <= ST_RD_ACK;
                                bit_cnt <= 4'd0;
                                SDA_OE  <= 1'b0;
                                SDA_OUT <= 1'b0;
                            end else begin
                                SDA_OUT <= rd_shift[14];
                            end
                        end
                    end

                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            master_nack <= sda_s;
                        end else if (scl_fall) begin
                            if (!second && !master_nack) begin
                                state   <= ST_RD_BYTE;
                                second  <= 1'b1;
                                bit_cnt <= 4'd0;
                                SDA_OE  <= 1'b1;
                                SDA_OUT <= rd_shift[15];
                            end else begin
                                state   <= ST_WAIT_STOP;
                            end
                        end
                    end

                    ST_WAIT_STOP: begin
                        SDA_OE <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// tb_i2c_target : directed, table-driven bench for i2c_target
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_target;

    logic        clk = 1'b0;
    logic        RESET;
    logic        SCL;
    logic        SDA_IN;
    logic        SDA_OUT;
    logic        SDA_OE;
    logic [15:0] RD_DATA;
    logic [15:0] WR_DATA;
    logic        WR_STB;
    logic        RD_STB;
    logic        BUSY;
`ifdef GENERAL_CALL_EN
    logic        GC_HIT;
`endif

    i2c_target dut (
        .clk     (clk),
        .RESET   (RESET),
        .SCL     (SCL),
        .SDA_IN  (SDA_IN),
        .SDA_OUT (SDA_OUT),
        .SDA_OE  (SDA_OE),
        .RD_DATA (RD_DATA),
        .WR_DATA (WR_DATA),
        .WR_STB  (WR_STB),
        .RD_STB  (RD_STB),
        .BUSY    (BUSY)
`ifdef GENERAL_CALL_EN
        ,
        .GC_HIT  (GC_HIT)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int wr_stb_cnt = 0;
    int rd_stb_cnt = 0;
    int oe_cnt = 0;

    always @(negedge clk) begin
        if (WR_STB) wr_stb_cnt++;
        if (RD_STB) rd_stb_cnt++;
        if (SDA_OE) oe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period: 8 clk low, 8 clk high; target outputs sampled mid-high.
    task automatic xfer_bit(input logic b, output logic oe, output logic out);
        SDA_IN = b;
        wait_clk(4);
        SCL = 1'b1;
        wait_clk(4);
        oe  = SDA_OE;
        out = SDA_OUT;
        wait_clk(4);
        SCL = 1'b0;
        wait_clk(4);
    endtask

    task automatic bus_start();
        if (SCL == 1'b0) begin
            SDA_IN = 1'b1;
            wait_clk(4);
            SCL = 1'b1;
            wait_clk(4);
        end
        SDA_IN = 1'b0;
        wait_clk(4);
        SCL = 1'b0;
        wait_clk(4);
    endtask

    task automatic bus_stop();
        SDA_IN = 1'b0;
        wait_clk(4);
        SCL = 1'b1;
        wait_clk(4);
        SDA_IN = 1'b1;
        wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic oe, out;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], oe, out);
        xfer_bit(1'b1, oe, out);
        acked = oe && !out;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d,
                             output logic all_oe, output logic ack_oe);
        logic oe, out;
        all_oe = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, oe, out);
            d[i]   = out;
            all_oe = all_oe & oe;
        end
        xfer_bit(mack, oe, out);
        ack_oe = oe;
    endtask

    typedef struct {
        string       name;
        logic [6:0]  addr;
        int          nbytes;
        logic [23:0] data;
        logic [3:0]  exp_ack;
        logic [15:0] exp_wr;
        int          exp_stb;
        logic        exp_busy;
        logic        exp_gc;
    } wvec_t;

    wvec_t       vec[5];
    logic [3:0]  ack_mask;
    logic        acked;
    logic        busy_mid;
    logic        gc_mid;
    logic [7:0]  rd_byte;
    logic        all_oe;
    logic        ack_oe;
    logic [15:0] exp_wr_now;
    int          stb_base;
    int          rd_base;
    int          oe_base;

    initial begin
        vec[0] = '{"wr_00ff",   7'h02, 2, 24'h00FF00, 4'b0111, 16'h00FF, 1, 1'b1, 1'b0};
        vec[1] = '{"bad_addr",  7'h05, 2, 24'h112200, 4'b0000, 16'h00FF, 0, 1'b0, 1'b0};
        vec[2] = '{"wr_3byte",  7'h02, 3, 24'h123456, 4'b0111, 16'h1234, 1, 1'b1, 1'b0};
        vec[3] = '{"wr_a55a",   7'h02, 2, 24'hA55A00, 4'b0111, 16'hA55A, 1, 1'b1, 1'b0};
`ifdef GENERAL_CALL_EN
        vec[4] = '{"gen_call",  7'h00, 2, 24'hBEEF00, 4'b0111, 16'hBEEF, 1, 1'b1, 1'b1};
`else
        vec[4] = '{"gen_call",  7'h00, 2, 24'hBEEF00, 4'b0000, 16'hA55A, 0, 1'b0, 1'b0};
`endif

        RESET   = 1'b0;
        SCL     = 1'b1;
        SDA_IN  = 1'b1;
        RD_DATA = 16'h0000;
        wait_clk(3);
        RESET = 1'b1;
        wait_clk(4);
        check("rst_sda_oe",  SDA_OE,  1'b0);
        check("rst_sda_out", SDA_OUT, 1'b0);
        check("rst_wr_data", WR_DATA, 16'h0000);
        check("rst_wr_stb",  WR_STB,  1'b0);
        check("rst_rd_stb",  RD_STB,  1'b0);
        check("rst_busy",    BUSY,    1'b0);
`ifdef GENERAL_CALL_EN
        check("rst_gc_hit",  GC_HIT,  1'b0);
`endif

        for (int v = 0; v < 5; v++) begin
            stb_base = wr_stb_cnt;
            oe_base  = oe_cnt;
            ack_mask = 4'b0000;
            bus_start();
            write_byte({vec[v].addr, 1'b0}, acked);
            ack_mask[0] = acked;
            for (int j = 0; j < vec[v].nbytes; j++) begin
                write_byte(vec[v].data[23-8*j -: 8], acked);
                ack_mask[j+1] = acked;
            end
            busy_mid = BUSY;
`ifdef GENERAL_CALL_EN
            gc_mid = GC_HIT;
`else
            gc_mid = 1'b0;
`endif
            bus_stop();
            wait_clk(2);
            check({vec[v].name, "_acks"},    ack_mask, vec[v].exp_ack);
            check({vec[v].name, "_wr_data"}, WR_DATA, vec[v].exp_wr);
            check({vec[v].name, "_wr_stb"},  wr_stb_cnt - stb_base, vec[v].exp_stb);
            check({vec[v].name, "_busy"},    busy_mid, vec[v].exp_busy);
            check({vec[v].name, "_busy_end"}, BUSY, 1'b0);
            check({vec[v].name, "_oe_seen"}, (oe_cnt - oe_base) > 0, vec[v].exp_ack[0]);
`ifdef GENERAL_CALL_EN
            check({vec[v].name, "_gc_mid"},  gc_mid, vec[v].exp_gc);
            check({vec[v].name, "_gc_end"},  GC_HIT, 1'b0);
`else
            if (gc_mid) check({vec[v].name, "_gc_mid"}, gc_mid, vec[v].exp_gc);
`endif
        end
        exp_wr_now = vec[4].exp_wr;

        // Read of A5C3; RD_DATA is changed after the address ACK to prove capture.
        RD_DATA  = 16'hA5C3;
        rd_base  = rd_stb_cnt;
        stb_base = wr_stb_cnt;
        bus_start();
        write_byte({7'h02, 1'b1}, acked);
        check("rd_addr_ack", acked, 1'b1);
        RD_DATA = 16'h0000;
        read_byte(1'b0, rd_byte, all_oe, ack_oe);
        check("rd_byte1",    rd_byte, 8'hA5);
        check("rd_byte1_oe", all_oe, 1'b1);
        check("rd_ack1_oe",  ack_oe, 1'b0);
        read_byte(1'b1, rd_byte, all_oe, ack_oe);
        check("rd_byte2",    rd_byte, 8'hC3);
        check("rd_byte2_oe", all_oe, 1'b1);
        check("rd_ack2_oe",  ack_oe, 1'b0);
        check("rd_oe_after", SDA_OE, 1'b0);
        check("rd_busy_mid", BUSY, 1'b1);
        bus_stop();
        wait_clk(2);
        check("rd_stb_cnt",  rd_stb_cnt - rd_base, 1);
        check("rd_no_wrstb", wr_stb_cnt - stb_base, 0);
        check("rd_busy_end", BUSY, 1'b0);

        // Aborted write followed by repeated START into a read.
        rd_base  = rd_stb_cnt;
        stb_base = wr_stb_cnt;
        bus_start();
        write_byte({7'h02, 1'b0}, acked);
        check("rs_waddr_ack", acked, 1'b1);
        write_byte(8'h12, acked);
        check("rs_wbyte_ack", acked, 1'b1);
        RD_DATA = 16'h3C96;
        bus_start();
        write_byte({7'h02, 1'b1}, acked);
        check("rs_raddr_ack", acked, 1'b1);
        read_byte(1'b0, rd_byte, all_oe, ack_oe);
        check("rs_rd_byte1", rd_byte, 8'h3C);
        read_byte(1'b1, rd_byte, all_oe, ack_oe);
        check("rs_rd_byte2", rd_byte, 8'h96);
        bus_stop();
        wait_clk(2);
        check("rs_wr_data",  WR_DATA, exp_wr_now);
        check("rs_wr_stb",   wr_stb_cnt - stb_base, 0);
        check("rs_rd_stb",   rd_stb_cnt - rd_base, 1);

        // Asynchronous reset in the middle of a read.
        RD_DATA = 16'hA5C3;
        bus_start();
        write_byte({7'h02, 1'b1}, acked);
        wait_clk(2);
        check("mr_oe_pre",   SDA_OE, 1'b1);
        check("mr_out_pre",  SDA_OUT, 1'b1);
        check("mr_busy_pre", BUSY, 1'b1);
        #1;
        RESET = 1'b0;
        #1;
        check("mr_oe",       SDA_OE, 1'b0);
        check("mr_out",      SDA_OUT, 1'b0);
        check("mr_busy",     BUSY, 1'b0);
        check("mr_wr_data",  WR_DATA, 16'h0000);
        SCL    = 1'b1;
        SDA_IN = 1'b1;
        wait_clk(4);
        RESET = 1'b1;
        wait_clk(4);
        check("mr_idle_oe",  SDA_OE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
